// File: rtl/clk_div_multi_pkg.sv
// clk_div_multi_pkg: shared defaults and limits for the multi-channel clock divider
package clk_div_multi_pkg;
    localparam int DEF_NUM_CH = 3;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_DIV    = 2;
    localparam int MIN_DIV    = 2;
endpackage

// File: rtl/clk_div_multi_ch.sv
// clk_div_multi_ch: one divider channel with counter, pending/active ratio and clamp
module clk_div_multi_ch
    import clk_div_multi_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RST_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb_i,
    input  logic             sync_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             ack_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d, cnt_inc;
    logic             clk_q, clk_d, tick_q, tick_d, ack_q, ack_d, pflag_q, pflag_d;
    logic             restart, step, apply;

    // next state: restart beats hold beats count; pending ratio swaps in only at a boundary
    always_comb begin
        restart = sync_i || !en_i;
        step    = !restart && enb_i;
        cnt_inc = (cnt_q == act_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
        cnt_d   = restart ? '0 : step ? cnt_inc : cnt_q;
        clk_d   = restart ? 1'b0 : step ? (cnt_inc != '0 && cnt_inc <= (act_q >> 1)) : clk_q;
        tick_d  = step && cnt_inc == CNT_W'(1);
        apply   = pflag_q && (restart || (step && cnt_inc == '0));
        ack_d   = apply;
        act_d   = apply ? pend_q : act_q;
        pend_d  = load_i ? ((div_i < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_i) : pend_q;
        pflag_d = load_i || (pflag_q && !apply);
    end

    // channel state register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            act_q   <= CNT_W'(RST_DIV);
            pend_q  <= CNT_W'(RST_DIV);
            pflag_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign ack_o  = ack_q;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable clock dividers sharing reset, hold and resync
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = clk_div_multi_pkg::DEF_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic                    sync,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] div,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH-1:0]       load_ack,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_multi_ch #(
            .CNT_W  (CNT_W),
            .RST_DIV(DEF_DIV << i)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .enb_i (enb),
            .sync_i(sync),
            .en_i  (ch_en[i]),
            .load_i(load[i]),
            .div_i (div[i*CNT_W +: CNT_W]),
            .clk_o (clk_out[i]),
            .tick_o(tick[i]),
            .ack_o (load_ack[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench; stimulus queues expected outputs, monitor compares
module tb_clk_div_multi;
  typedef struct packed {
    logic [2:0] c;
    logic [2:0] t;
    logic [2:0] a;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst, enb, sync;
  logic [2:0]  ch_en, load, load_ack, clk_out, tick;
  logic [23:0] div;
  exp_t  q[$];
  event  samp;
  string tag = "reset";
  int    n_cmp = 0, n_bad = 0;
  int    p[3], r[3], pr[3];
  bit    pf[3], ck[3];
  clk_div_multi dut (
    .clk(clk), .rst(rst), .enb(enb), .sync(sync), .ch_en(ch_en),
    .div(div), .load(load), .load_ack(load_ack), .clk_out(clk_out), .tick(tick)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 -> samp;
  end
  initial begin
    exp_t e;
    forever begin
      @(samp);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({clk_out, tick, load_ack} !== e) begin
          n_bad++;
          $display("FAIL %s @%0t: got clk_out=%b tick=%b load_ack=%b, expected clk_out=%b tick=%b load_ack=%b",
                   tag, $time, clk_out, tick, load_ack, e.c, e.t, e.a);
        end
      end
    end
  end
  task automatic chk_zero(input string s);
    n_cmp++;
    if ({clk_out, tick, load_ack} !== 9'b0) begin
      n_bad++;
      $display("FAIL %s @%0t: got clk_out=%b tick=%b load_ack=%b, expected all zero",
               s, $time, clk_out, tick, load_ack);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      p[i] = 0; r[i] = 2 << i; pr[i] = 2 << i; pf[i] = 0; ck[i] = 0;
    end
  endtask
  task automatic cyc(input bit mid_rst);
    exp_t e;
    e = '0;
    if (!rst) model_reset();
    else for (int i = 0; i < 3; i++) begin
      bit ap;
      int v;
      ap = 0;
      if (sync || !ch_en[i]) begin
        p[i] = 0; ck[i] = 0; ap = pf[i];
      end else if (enb) begin
        p[i]   = (p[i] + 1) % r[i];
        ck[i]  = p[i] >= 1 && p[i] <= r[i] / 2;
        e.t[i] = p[i] == 1;
        ap     = pf[i] && p[i] == 0;
      end
      if (ap) begin
        r[i] = pr[i]; pf[i] = 0; e.a[i] = 1'b1;
      end
      if (load[i]) begin
        v = int'(div[i*8 +: 8]);
        pr[i] = v < 2 ? 2 : v; pf[i] = 1;
      end
      e.c[i] = ck[i];
    end
    q.push_back(e);
    if (mid_rst) begin
      @(posedge clk);
      #3 rst = 1'b0;
      model_reset();
      tag = "async_reset";
      q.push_back('0);
      #1 -> samp;
      chk_zero("async_reset_direct");
    end
    @(negedge clk);
  endtask
  task automatic run(input int n);
    for (int j = 0; j < n; j++) cyc(0);
  endtask
  initial begin
    rst = 1'b0; enb = 1'b1; sync = 1'b0; ch_en = 3'b111; load = '0; div = '0;
    model_reset();
    #1 chk_zero("reset_state");
    @(negedge clk);
    run(2);
    tag = "defaults";
    rst = 1'b1;
    run(20);
    tag = "hold";
    enb = 1'b0;
    run(6);
    enb = 1'b1;
    tag = "resume";
    run(10);
    tag = "ratio_change";
    for (int j = 0; j < 16 && p[1] != 1; j++) cyc(0);
    div[15:8] = 8'd6; load = 3'b010;
    cyc(0);
    load = '0;
    run(16);
    tag = "clamp_overwrite";
    for (int j = 0; j < 16 && p[2] != 1; j++) cyc(0);
    div[23:16] = 8'd1; load = 3'b100;
    cyc(0);
    div[23:16] = 8'd5;
    cyc(0);
    load = '0;
    run(20);
    tag = "sync_align";
    div = {8'd4, 8'd4, 8'd4}; load = 3'b111;
    cyc(0);
    load = '0; sync = 1'b1;
    cyc(0);
    sync = 1'b0;
    run(12);
    tag = "ch_disable";
    ch_en = 3'b011;
    run(4);
    ch_en = 3'b111;
    run(8);
    tag = "load_disabled";
    ch_en = 3'b101; div[15:8] = 8'd3; load = 3'b010;
    cyc(0);
    load = '0;
    run(2);
    ch_en = 3'b111;
    run(8);
    tag = "pre_reset";
    cyc(1);
    tag = "in_reset";
    run(2);
    rst = 1'b1;
    tag = "after_reset";
    run(12);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
